// File: rtl/multiplier_2x3.sv
// Unsigned 2-bit x 3-bit multiplier: AND-gate partial products reduced by
// half/full adders, followed by a single register stage qualified by in_valid.

module multiplier_2x3 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [1:0] m,
    input  logic [2:0] q,
    output logic [4:0] p,
    output logic       out_valid
);

    // Adder cells return {carry, sum}.
    function automatic logic [1:0] halfAdd(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    function automatic logic [1:0] fullAdd(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [2:0] w_pp0;
    logic [2:0] w_pp1;
    logic [1:0] w_bit1;
    logic [1:0] w_bit2;
    logic [1:0] w_bit3;
    logic [4:0] w_prod;

    assign w_pp0 = {3{m[0]}} & q;
    assign w_pp1 = {3{m[1]}} & q;

    // Row 1 is shifted by one column; each column feeds its carry upward.
    assign w_bit1 = halfAdd(w_pp0[1], w_pp1[0]);
    assign w_bit2 = fullAdd(w_pp0[2], w_pp1[1], w_bit1[1]);
    assign w_bit3 = halfAdd(w_pp1[2], w_bit2[1]);

    assign w_prod = {w_bit3[1], w_bit3[0], w_bit2[0], w_bit1[0], w_pp0[0]};

    logic [4:0] r_p;
    logic       r_outValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p        <= 5'd0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= in_valid;
            if (in_valid) begin
                r_p <= w_prod;
            end
        end
    end

    assign p         = r_p;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_multiplier_2x3.sv
// Directed, table-driven self-checking bench for multiplier_2x3.

module tb_multiplier_2x3;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] m;
    logic [2:0] q;
    logic [4:0] p;
    logic       out_valid;

    int checks;
    int failures;

    typedef struct {
        logic [1:0] m;
        logic [2:0] q;
        logic [4:0] expP;
    } vec_t;

    vec_t corners [5];

    multiplier_2x3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .m         (m),
        .q         (q),
        .p         (p),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one input set, then advances to just after the next rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] mi, input logic [2:0] qi);
        in_valid = v;
        m        = mi;
        q        = qi;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] expP, input logic expV);
        checks++;
        if (p !== expP || out_valid !== expV) begin
            failures++;
            $display("[TB] FAIL %s: p=%0d out_valid=%b, required p=%0d out_valid=%b",
                     name, p, out_valid, expP, expV);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        corners[0] = '{m: 2'd0, q: 3'd7, expP: 5'd0};
        corners[1] = '{m: 2'd3, q: 3'd0, expP: 5'd0};
        corners[2] = '{m: 2'd1, q: 3'd1, expP: 5'd1};
        corners[3] = '{m: 2'd3, q: 3'd7, expP: 5'd21};
        corners[4] = '{m: 2'd2, q: 3'd4, expP: 5'd8};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        m        = 2'd0;
        q        = 3'd0;
        #1;
        checkOutput("reset_state", 5'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Exhaustive sweep, q outer and m inner.
        for (int qi = 0; qi < 8; qi++) begin
            for (int mi = 0; mi < 4; mi++) begin
                applyStimulus(1'b1, 2'(mi), 3'(qi));
                checkOutput($sformatf("sweep_m%0d_q%0d", mi, qi), 5'(mi * qi), 1'b1);
            end
        end

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, corners[i].m, corners[i].q);
            checkOutput($sformatf("corner_%0d", i), corners[i].expP, 1'b1);
        end

        // Hold with changing and unknown inputs while in_valid is low.
        applyStimulus(1'b1, 2'd3, 3'd5);
        checkOutput("hold_capture", 5'd15, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'd1, 3'd1);
            checkOutput($sformatf("hold_%0d", i), 5'd15, 1'b0);
        end
        applyStimulus(1'b0, 2'bxx, 3'bxxx);
        checkOutput("hold_x_inputs", 5'd15, 1'b0);

        // Async reset between edges.
        applyStimulus(1'b1, 2'd3, 3'd7);
        checkOutput("pre_reset", 5'd21, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 5'd0, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd2, 3'd3);
        checkOutput("post_reset_first", 5'd6, 1'b1);

        // Reset dominates in_valid across several edges.
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 2'd3, 3'd7);
            checkOutput($sformatf("reset_priority_%0d", i), 5'd0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back alternation.
        applyStimulus(1'b1, 2'd3, 3'd7);
        checkOutput("b2b_0", 5'd21, 1'b1);
        applyStimulus(1'b1, 2'd0, 3'd0);
        checkOutput("b2b_1", 5'd0, 1'b1);
        applyStimulus(1'b1, 2'd3, 3'd7);
        checkOutput("b2b_2", 5'd21, 1'b1);
        applyStimulus(1'b0, 2'd0, 3'd0);
        checkOutput("b2b_idle", 5'd21, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
